// File: rtl/tx_frame_ctrl_if.sv
// Payload stream into the frame controller: word, valid, end-of-frame marker and ready.
interface tx_frame_ctrl_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_last;
   logic              s_ready;

   modport master (output s_data, output s_valid, output s_last, input s_ready);
   modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/tx_frame_ctrl.sv
// Frame controller: clears the convolutional encoder, shifts payload words into it MSB first,
// appends zero flush bits and re-times the coded bit with frame markers.
module tx_frame_ctrl #(
   parameter int DATA_W   = 8,
   parameter int TAIL_LEN = 6
) (
   input  logic           clk,
   input  logic           reset,
   tx_frame_ctrl_if.slave str,
   output logic           enc_in,
   output logic           enc_rst_n,
   input  logic           enc_out,
   output logic           tx_bit,
   output logic           tx_valid,
   output logic           tx_sof,
   output logic           tx_eof,
   output logic           busy,
   output logic           underrun
);

   localparam int CNT_W  = $clog2(DATA_W);
   localparam int TCNT_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [TCNT_W-1:0] TAIL_LAST = TCNT_W'(TAIL_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DATA  = 2'd2,
      TAIL  = 2'd3
   } state_t;

   state_t              state_r, state_s;
   logic [DATA_W-1:0]   shift_r, shift_s;
   logic                last_r, last_s;
   logic                first_r, first_s;
   logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_s;
   logic [TCNT_W-1:0]   tail_cnt_r, tail_cnt_s;
   logic                underrun_s;
   logic                ready_s;
   logic                enc_in_s;
   logic                bit_end_s;
   logic                tx_active_s;

   assign bit_end_s   = (bit_cnt_r == BIT_LAST);
   assign tx_active_s = (state_r == DATA) || (state_r == TAIL);

   // Reset gates the handshake and encoder controls immediately, ahead of the state flop.
   assign str.s_ready = ready_s & ~reset;
   assign enc_in      = enc_in_s & ~reset;
   assign enc_rst_n   = ~reset & (state_r != CLEAR);
   assign busy        = (state_r != IDLE);

   // Next-state, datapath update and handshake decode.
   always_comb begin
      state_s    = state_r;
      shift_s    = shift_r;
      last_s     = last_r;
      first_s    = first_r;
      bit_cnt_s  = bit_cnt_r;
      tail_cnt_s = tail_cnt_r;
      underrun_s = 1'b0;
      ready_s    = 1'b0;
      enc_in_s   = 1'b0;
      case (state_r)
         IDLE: begin
            ready_s = 1'b1;
            if (str.s_valid) begin
               shift_s = str.s_data;
               last_s  = str.s_last;
               state_s = CLEAR;
            end else begin
               state_s = IDLE;
            end
         end
         CLEAR: begin
            bit_cnt_s = {CNT_W{1'b0}};
            first_s   = 1'b1;
            state_s   = DATA;
         end
         DATA: begin
            enc_in_s = shift_r[DATA_W-1];
            first_s  = 1'b0;
            ready_s  = bit_end_s & ~last_r;
            if (bit_end_s) begin
               if (last_r) begin
                  tail_cnt_s = {TCNT_W{1'b0}};
                  state_s    = TAIL;
               end else if (str.s_valid) begin
                  // Next word continues the frame with no idle bit between words.
                  shift_s   = str.s_data;
                  last_s    = str.s_last;
                  bit_cnt_s = {CNT_W{1'b0}};
               end else begin
                  underrun_s = 1'b1;
                  tail_cnt_s = {TCNT_W{1'b0}};
                  state_s    = TAIL;
               end
            end else begin
               shift_s   = {shift_r[DATA_W-2:0], 1'b0};
               bit_cnt_s = bit_cnt_r + CNT_W'(1);
            end
         end
         TAIL: begin
            if (tail_cnt_r == TAIL_LAST) begin
               tail_cnt_s = {TCNT_W{1'b0}};
               bit_cnt_s  = {CNT_W{1'b0}};
               state_s    = IDLE;
            end else begin
               tail_cnt_s = tail_cnt_r + TCNT_W'(1);
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered output stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         shift_r    <= {DATA_W{1'b0}};
         last_r     <= 1'b0;
         first_r    <= 1'b0;
         bit_cnt_r  <= {CNT_W{1'b0}};
         tail_cnt_r <= {TCNT_W{1'b0}};
         tx_bit     <= 1'b0;
         tx_valid   <= 1'b0;
         tx_sof     <= 1'b0;
         tx_eof     <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state_r    <= state_s;
         shift_r    <= shift_s;
         last_r     <= last_s;
         first_r    <= first_s;
         bit_cnt_r  <= bit_cnt_s;
         tail_cnt_r <= tail_cnt_s;
         tx_bit     <= tx_active_s & enc_out;
         tx_valid   <= tx_active_s;
         tx_sof     <= (state_r == DATA) & first_r;
         tx_eof     <= (state_r == TAIL) & (tail_cnt_r == TAIL_LAST);
         underrun   <= underrun_s;
      end
   end

endmodule
